cacheline_adapter: RTL and testbench
====================================

# cacheline_adapter

Parametrised cache-line/burst-memory adapter, the successor to the read-only instruction-side adapter. It serves one cache port with both line fills (read bursts) and line writebacks (write bursts). Line width, beat width and address width are parameters. It sits between an L1 cache's DFP port and the burst memory model or controller. An optional single-line buffer can answer repeated fills without touching memory.

## Interface
Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, burst beat width in bits.
- Derived values:
  - BEATS = LINE_W/BEAT_W, which must be a power of two and at least 2.
  - OFF_W = $clog2(LINE_W/8).
  - CNT_W = $clog2(BEATS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- dfp_addr  in  ADDR_W  request address. Offset bits are ignored.
- dfp_read  in  1  line fill request. Held high by the cache until dfp_resp.
- dfp_write  in  1  line writeback request. Held high by the cache until dfp_resp.
- dfp_wdata  in  LINE_W  writeback line. Held stable with dfp_write.
- dfp_resp  out  1  one-cycle completion pulse.
- dfp_rdata  out  LINE_W  fill line. Valid only while dfp_resp=1, otherwise 0.
- bmem_addr  out  ADDR_W  line-aligned burst address: {addr[ADDR_W-1:OFF_W], OFF_W'b0}.
- bmem_read  out  1  burst read request.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_W  write beat.
- bmem_ready  in  1  memory accepts a request or write beat this cycle.
- bmem_rvalid  in  1  read beat valid.
- bmem_rdata  in  BEAT_W  read beat.

## Operation
States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.

- **IDLE**
  - dfp_write: latch the aligned address and dfp_wdata, clear the counter, go to WR_DATA. Write wins if dfp_read and dfp_write are both high.
  - Else dfp_read: latch the aligned address, clear the counter and assembled line, go to RD_REQ.
- **RD_REQ**
  - Drive bmem_read=1 and bmem_addr.
  - Go to RD_DATA on the cycle bmem_ready=1, otherwise stay.
- **RD_DATA**
  - Each bmem_rvalid beat k (counting from 0) is written to line[k*BEAT_W +: BEAT_W], then the counter increments.
  - Gaps in rvalid are legal. The counter holds across gaps and is never cleared by rvalid low.
  - When the last beat (k=BEATS-1) arrives, go to RESP.
- **WR_DATA**
  - Drive bmem_write=1 and bmem_addr.
  - Drive bmem_wdata = latched_line[cnt*BEAT_W +: BEAT_W].
  - A beat transfers when bmem_ready=1, and then the counter increments.
  - After the last beat transfers, go to RESP.
- **RESP**
  - dfp_resp=1 for exactly one cycle.
  - dfp_rdata = assembled line after a read, 0 after a write.
  - Go to IDLE.

Rules:
- bmem_rvalid outside RD_DATA is ignored and does not modify the line or the counter.
- bmem_addr, bmem_wdata and dfp_rdata are 0 in any state that does not drive them.
- Reset in any state returns to IDLE next cycle and aborts any burst; a partial line is discarded.

## Timing
- Reset values:
  - state=IDLE, counter=0, line=0.
  - All outputs are 0: dfp_resp, dfp_rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata.
- Read latency: request seen in IDLE at cycle N gives bmem_read at N+1 at the earliest. dfp_resp comes one cycle after the last rvalid beat.
- Write latency: request at N gives the first beat at N+1. With ready always high, dfp_resp occurs at N+BEATS+1.
- A new request is sampled no earlier than the cycle after RESP, so a held request is never double-issued.

## Configuration
- Macro: CACHELINE_ADAPTER_LINEBUF_EN.
- Defined: adds a one-entry buffer {valid, line address, line}.
  - A completed read fill loads the buffer and sets valid.
  - In IDLE, a dfp_read whose line address matches a valid entry goes directly to RESP with the buffered line. No bmem activity; dfp_resp comes at N+1.
  - A dfp_write to the matching line clears valid.
  - rst clears valid.
- Undefined: no buffer. Every read performs a full burst.

## Test plan
- **Single read burst:** LINE_W=256, BEAT_W=64. dfp_read at addr 0x1234_5678 with ready=1 and beats 0xA0..A3 on consecutive cycles.
  - Expect bmem_addr=0x1234_5660.
  - Expect dfp_rdata = {A3,A2,A1,A0} with dfp_resp for one cycle.
- **Read with rvalid gaps and a ready stall:** ready low for 3 cycles, then beats separated by idle cycles.
  - Expect bmem_read held through the stall, the same assembled line, and resp exactly once.
- **Writeback:** dfp_wdata={D3,D2,D1,D0} at 0x40, with ready toggling 1,0,1,1,1.
  - Expect bmem_wdata to present D0..D3 in order, each held while ready=0.
  - Expect dfp_resp one cycle after D3 transfers.
- **Read and write high together:**
  - Expect the write burst only, and rdata=0 at resp.
- **Reset mid-burst:** assert rst after 2 read beats, then issue a new read.
  - Expect all outputs 0 the cycle after rst.
  - Expect the new line to contain only the new beats.
- **CACHELINE_ADAPTER_LINEBUF_EN:**
  - Repeat a read of 0x80: resp at N+1 with no bmem_read.
  - Write to 0x80, then read 0x80: a full burst is issued.

Source files
------------

// File: rtl/cacheline_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter_if
// Description : Bundles the cache-side DFP port and the burst-memory port of
//               the cache-line adapter.
//               slave  : adapter view. It serves the cache (dfp_*) and drives
//                        the burst memory (bmem_*).
//               master : environment view. This is the cache together with
//                        the memory model.
//               DFP    : dfp_addr, dfp_read, dfp_write, dfp_wdata  -> adapter
//                        dfp_resp, dfp_rdata                      <- adapter
//               BMEM   : bmem_addr, bmem_read, bmem_write,
//                        bmem_wdata                               <- adapter
//                        bmem_ready, bmem_rvalid, bmem_rdata      -> adapter
// Revision    : 1.0 - initial release
// ============================================================================
interface cacheline_adapter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
);
   logic [ADDR_W-1:0] dfp_addr;
   logic              dfp_read;
   logic              dfp_write;
   logic [LINE_W-1:0] dfp_wdata;
   logic              dfp_resp;
   logic [LINE_W-1:0] dfp_rdata;

   logic [ADDR_W-1:0] bmem_addr;
   logic              bmem_read;
   logic              bmem_write;
   logic [BEAT_W-1:0] bmem_wdata;
   logic              bmem_ready;
   logic              bmem_rvalid;
   logic [BEAT_W-1:0] bmem_rdata;

   modport slave (
      input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
      output dfp_resp, dfp_rdata,
      output bmem_addr, bmem_read, bmem_write, bmem_wdata,
      input  bmem_ready, bmem_rvalid, bmem_rdata
   );

   modport master (
      output dfp_addr, dfp_read, dfp_write, dfp_wdata,
      input  dfp_resp, dfp_rdata,
      input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
      output bmem_ready, bmem_rvalid, bmem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter
// Description : Cache-line / burst-memory adapter. It turns a line fill into
//               a burst read and a line writeback into a burst write of
//               LINE_W/BEAT_W beats. A single FSM handles both directions:
//               IDLE -> RD_REQ -> RD_DATA -> RESP and IDLE -> WR_DATA -> RESP.
//               Optional macro CACHELINE_ADAPTER_LINEBUF_EN adds a one-line
//               buffer. A repeated fill of the most recently filled line is
//               then answered without any memory traffic.
// Ports       : clk, rst  - clock and synchronous active-high reset
//               bus       - cacheline_adapter_if.slave (dfp_* and bmem_*)
// Parameters  : ADDR_W (byte address width), LINE_W (line bits),
//               BEAT_W (beat bits). LINE_W/BEAT_W must be a power of two
//               and at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adapter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input  wire logic             clk,
   input  wire logic             rst,
   cacheline_adapter_if.slave    bus
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int CNT_W = $clog2(BEATS);
   localparam int TAG_W = ADDR_W - OFF_W;

   localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BEATS - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_REQ  = 3'd1;
   localparam logic [2:0] S_RD_DATA = 3'd2;
   localparam logic [2:0] S_WR_DATA = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [TAG_W-1:0]  r_tag;      // line address of the active transaction
   logic [CNT_W-1:0]  r_cnt;      // beat index within the burst
   logic [LINE_W-1:0] r_line;     // write line to send, or read line being assembled
   logic              r_rd;       // active transaction is a fill (selects dfp_rdata)

   logic [TAG_W-1:0]  w_req_tag;
   logic              w_buf_hit;
   logic [LINE_W-1:0] w_buf_line;
   logic [BEAT_W-1:0] w_beat [BEATS];

   assign w_req_tag = bus.dfp_addr[ADDR_W-1:OFF_W];

   // Split the line into beats so the outgoing write beat is a plain mux on r_cnt.
   for (genvar g = 0; g < BEATS; g++) begin : g_beat
      assign w_beat[g] = r_line[g*BEAT_W +: BEAT_W];
   end

`ifdef CACHELINE_ADAPTER_LINEBUF_EN
   logic              r_buf_valid;
   logic [TAG_W-1:0]  r_buf_tag;
   logic [LINE_W-1:0] r_buf_line;

   assign w_buf_hit  = r_buf_valid && (r_buf_tag == w_req_tag);
   assign w_buf_line = r_buf_line;

   // Load on every completed fill. Invalidate on a writeback to the buffered
   // line so that a later fill fetches the fresh data from memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf_valid <= 1'b0;
         r_buf_tag   <= '0;
         r_buf_line  <= '0;
      end else if (r_state == S_RESP && r_rd) begin
         r_buf_valid <= 1'b1;
         r_buf_tag   <= r_tag;
         r_buf_line  <= r_line;
      end else if (r_state == S_IDLE && bus.dfp_write && w_buf_hit) begin
         r_buf_valid <= 1'b0;
      end
   end
`else
   assign w_buf_hit  = 1'b0;
   assign w_buf_line = '0;
`endif

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            // A writeback takes priority over a fill when both are requested.
            if (bus.dfp_write) begin
               w_state_nxt = S_WR_DATA;
            end else if (bus.dfp_read) begin
               w_state_nxt = w_buf_hit ? S_RESP : S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (bus.bmem_ready) begin
               w_state_nxt = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (bus.bmem_rvalid && r_cnt == C_LAST_BEAT) begin
               w_state_nxt = S_RESP;
            end
         end
         S_WR_DATA: begin
            if (bus.bmem_ready && r_cnt == C_LAST_BEAT) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      bus.dfp_resp   = 1'b0;
      bus.dfp_rdata  = '0;
      bus.bmem_addr  = '0;
      bus.bmem_read  = 1'b0;
      bus.bmem_write = 1'b0;
      bus.bmem_wdata = '0;
      case (r_state)
         S_RD_REQ: begin
            bus.bmem_read = 1'b1;
            bus.bmem_addr = {r_tag, {OFF_W{1'b0}}};
         end
         S_WR_DATA: begin
            bus.bmem_write = 1'b1;
            bus.bmem_addr  = {r_tag, {OFF_W{1'b0}}};
            bus.bmem_wdata = w_beat[r_cnt];
         end
         S_RESP: begin
            bus.dfp_resp  = 1'b1;
            bus.dfp_rdata = r_rd ? r_line : '0;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag  <= '0;
         r_cnt  <= '0;
         r_line <= '0;
         r_rd   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.dfp_write) begin
                  r_tag  <= w_req_tag;
                  r_cnt  <= '0;
                  r_line <= bus.dfp_wdata;
                  r_rd   <= 1'b0;
               end else if (bus.dfp_read) begin
                  r_tag  <= w_req_tag;
                  r_cnt  <= '0;
                  // On a buffer hit the FSM skips to RESP, so the line is taken from the buffer.
                  r_line <= w_buf_hit ? w_buf_line : '0;
                  r_rd   <= 1'b1;
               end
            end
            S_RD_DATA: begin
               // Beats may arrive with gaps. The counter advances only on rvalid.
               if (bus.bmem_rvalid) begin
                  for (int k = 0; k < BEATS; k++) begin
                     if (r_cnt == CNT_W'(k)) begin
                        r_line[k*BEAT_W +: BEAT_W] <= bus.bmem_rdata;
                     end
                  end
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WR_DATA: begin
               if (bus.bmem_ready) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adapter
// Description : Directed self-checking bench for cacheline_adapter with
//               LINE_W=256, BEAT_W=64 (4 beats). It covers read bursts,
//               stalls and rvalid gaps, writeback with ready stalls,
//               read/write collision, reset mid-burst, and the optional
//               line buffer (CACHELINE_ADAPTER_LINEBUF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adapter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;
   localparam int BEAT_W = 64;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   cacheline_adapter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();

   cacheline_adapter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".resp"},   {255'd0, bus.dfp_resp},   256'd0);
      chk({tag, ".rdata"},  bus.dfp_rdata,              256'd0);
      chk({tag, ".bread"},  {255'd0, bus.bmem_read},  256'd0);
      chk({tag, ".bwrite"}, {255'd0, bus.bmem_write}, 256'd0);
      chk({tag, ".baddr"},  {224'd0, bus.bmem_addr},  256'd0);
      chk({tag, ".bwdata"}, {192'd0, bus.bmem_wdata}, 256'd0);
   endtask

   // Full fill with ready=1 and back-to-back beats taken from 'line'.
   task automatic do_fill(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_baddr, input logic [255:0] line);
      bus.dfp_addr   = addr;
      bus.dfp_read   = 1'b1;
      bus.bmem_ready = 1'b1;
      tick();
      chk({tag, ".bread"}, {255'd0, bus.bmem_read}, 256'd1);
      chk({tag, ".baddr"}, {224'd0, bus.bmem_addr}, {224'd0, exp_baddr});
      tick();
      for (int b = 0; b < 4; b++) begin
         bus.bmem_rvalid = 1'b1;
         bus.bmem_rdata  = line[b*64 +: 64];
         tick();
      end
      bus.bmem_rvalid = 1'b0;
      bus.bmem_rdata  = '0;
      chk({tag, ".resp"},  {255'd0, bus.dfp_resp}, 256'd1);
      chk({tag, ".rdata"}, bus.dfp_rdata, line);
      // The request stays high through RESP and must not be re-issued.
      tick();
      bus.dfp_read = 1'b0;
      chk({tag, ".resp_done"}, {255'd0, bus.dfp_resp}, 256'd0);
      chk({tag, ".no_reissue"}, {255'd0, bus.bmem_read}, 256'd0);
   endtask

   logic [255:0] v_line;

   initial begin
      checks          = 0;
      failures        = 0;
      rst             = 1'b1;
      bus.dfp_addr    = '0;
      bus.dfp_read    = 1'b0;
      bus.dfp_write   = 1'b0;
      bus.dfp_wdata   = '0;
      bus.bmem_ready  = 1'b0;
      bus.bmem_rvalid = 1'b0;
      bus.bmem_rdata  = '0;

      // ---------------- reset
      tick();
      tick();
      chk_idle_outputs("reset");
      rst = 1'b0;

      // ---------------- single read burst
      v_line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
      do_fill("rd1", 32'h1234_5678, 32'h1234_5660, v_line);

      // ---------------- read with ready stall and rvalid gaps
      bus.dfp_addr    = 32'h0000_0100;
      bus.dfp_read    = 1'b1;
      bus.bmem_ready  = 1'b0;
      bus.bmem_rvalid = 1'b1;             // stray rvalid during RD_REQ is ignored
      bus.bmem_rdata  = 64'hDEAD;
      tick();
      for (int s = 0; s < 3; s++) begin
         chk("rd2.stall_bread", {255'd0, bus.bmem_read}, 256'd1);
         if (s < 2) tick();
      end
      bus.bmem_ready  = 1'b1;
      bus.bmem_rvalid = 1'b0;
      tick();                             // still in RD_REQ for the 3rd stall cycle -> accepted now
      chk("rd2.bread_drop", {255'd0, bus.bmem_read}, 256'd0);
      bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'hB0; tick();
      bus.bmem_rvalid = 1'b0; tick();
      bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'hB1; tick();
      bus.bmem_rvalid = 1'b0; tick(); tick();
      bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'hB2; tick();
      bus.bmem_rvalid = 1'b0; tick();
      chk("rd2.no_early_resp", {255'd0, bus.dfp_resp}, 256'd0);
      bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'hB3; tick();
      bus.bmem_rvalid = 1'b0;
      chk("rd2.resp",  {255'd0, bus.dfp_resp}, 256'd1);
      chk("rd2.rdata", bus.dfp_rdata, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
      bus.dfp_read = 1'b0;
      tick();
      chk("rd2.resp_once", {255'd0, bus.dfp_resp}, 256'd0);

      // ---------------- writeback with ready 1,0,1,1,1
      bus.dfp_addr   = 32'h0000_0040;
      bus.dfp_wdata  = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
      bus.dfp_write  = 1'b1;
      bus.bmem_ready = 1'b1;
      tick();
      chk("wr.bwrite", {255'd0, bus.bmem_write}, 256'd1);
      chk("wr.baddr",  {224'd0, bus.bmem_addr}, 256'h40);
      chk("wr.d0",     {192'd0, bus.bmem_wdata}, 256'hD0);
      tick();
      chk("wr.d1",     {192'd0, bus.bmem_wdata}, 256'hD1);
      bus.bmem_ready = 1'b0;
      tick();
      chk("wr.d1_held", {192'd0, bus.bmem_wdata}, 256'hD1);
      bus.bmem_ready = 1'b1;
      tick();
      chk("wr.d2",     {192'd0, bus.bmem_wdata}, 256'hD2);
      tick();
      chk("wr.d3",     {192'd0, bus.bmem_wdata}, 256'hD3);
      chk("wr.no_early_resp", {255'd0, bus.dfp_resp}, 256'd0);
      tick();
      chk("wr.resp",   {255'd0, bus.dfp_resp}, 256'd1);
      chk("wr.rdata0", bus.dfp_rdata, 256'd0);
      chk("wr.bwrite_off", {255'd0, bus.bmem_write}, 256'd0);
      bus.dfp_write = 1'b0;
      tick();

      // ---------------- read and write together: write wins
      bus.dfp_addr  = 32'h0000_0200;
      bus.dfp_wdata = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
      bus.dfp_read  = 1'b1;
      bus.dfp_write = 1'b1;
      tick();
      chk("rw.bwrite", {255'd0, bus.bmem_write}, 256'd1);
      chk("rw.bread",  {255'd0, bus.bmem_read}, 256'd0);
      chk("rw.baddr",  {224'd0, bus.bmem_addr}, 256'h200);
      tick(); tick(); tick(); tick();     // write at N: resp at N+BEATS+1
      chk("rw.resp",   {255'd0, bus.dfp_resp}, 256'd1);
      chk("rw.rdata0", bus.dfp_rdata, 256'd0);
      bus.dfp_read  = 1'b0;
      bus.dfp_write = 1'b0;
      tick();

      // ---------------- reset mid-burst
      bus.dfp_addr = 32'h0000_0300;
      bus.dfp_read = 1'b1;
      tick(); tick();
      bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'hF0; tick();
      bus.bmem_rdata = 64'hF1; tick();
      bus.bmem_rvalid = 1'b0;
      bus.dfp_read    = 1'b0;
      rst = 1'b1;
      tick();
      chk_idle_outputs("rst_mid");
      rst = 1'b0;
      bus.dfp_read = 1'b1;
      tick(); tick();
      bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'hC0; tick();
      bus.bmem_rdata = 64'hC1; tick();
      bus.bmem_rvalid = 1'b0;
      chk("rst_mid.cnt_cleared", {255'd0, bus.dfp_resp}, 256'd0);
      bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'hC2; tick();
      bus.bmem_rdata = 64'hC3; tick();
      bus.bmem_rvalid = 1'b0;
      chk("rst_mid.resp",  {255'd0, bus.dfp_resp}, 256'd1);
      chk("rst_mid.rdata", bus.dfp_rdata, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
      bus.dfp_read = 1'b0;
      tick();

`ifdef CACHELINE_ADAPTER_LINEBUF_EN
      // ---------------- line buffer hit / invalidation
      v_line = {64'h14, 64'h13, 64'h12, 64'h11};
      do_fill("lb.fill", 32'h0000_0080, 32'h0000_0080, v_line);
      bus.dfp_addr = 32'h0000_0084;       // same line, different offset
      bus.dfp_read = 1'b1;
      tick();
      chk("lb.hit_resp",  {255'd0, bus.dfp_resp}, 256'd1);
      chk("lb.hit_rdata", bus.dfp_rdata, v_line);
      chk("lb.hit_nobus", {255'd0, bus.bmem_read}, 256'd0);
      bus.dfp_read = 1'b0;
      tick();
      bus.dfp_addr  = 32'h0000_0080;
      bus.dfp_wdata = {64'h24, 64'h23, 64'h22, 64'h21};
      bus.dfp_write = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      chk("lb.wr_resp", {255'd0, bus.dfp_resp}, 256'd1);
      bus.dfp_write = 1'b0;
      tick();
      do_fill("lb.refill", 32'h0000_0080, 32'h0000_0080, {64'h34, 64'h33, 64'h32, 64'h31});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
